// File: rtl/vga_io_pkg.sv
// Shared constants for the VGA CPU I/O front end: port map, CRTC indices,
// DAC phase encoding, video modes and the 6-to-8-bit DAC component expansion.
package vga_io_pkg;

  localparam logic [15:0] PORT_DAC_RIDX  = 16'h03C7;
  localparam logic [15:0] PORT_DAC_WIDX  = 16'h03C8;
  localparam logic [15:0] PORT_DAC_DATA  = 16'h03C9;
  localparam logic [15:0] PORT_CRTC_IDX  = 16'h03D4;
  localparam logic [15:0] PORT_CRTC_DATA = 16'h03D5;
  localparam logic [15:0] PORT_MODE      = 16'h03D8;
  localparam logic [15:0] PORT_STATUS    = 16'h03DA;

  localparam logic [7:0] CRTC_CUR_START = 8'h0A;
  localparam logic [7:0] CRTC_CUR_END   = 8'h0B;
  localparam logic [7:0] CRTC_CUR_HI    = 8'h0E;
  localparam logic [7:0] CRTC_CUR_LO    = 8'h0F;

  localparam logic [3:0] CUR_SL_RESET = 4'hE;
  localparam logic [3:0] CUR_SH_RESET = 4'hF;

  localparam logic [1:0] MODE_TEXT   = 2'd0;
  localparam logic [1:0] MODE_VGA256 = 2'd2;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } dac_phase_t;

  // Replicates the top bits into the low end so 6'h3F maps to full-scale 8'hFF.
  function automatic logic [7:0] dac_expand(input logic [5:0] c, input int unsigned shift);
    return ({2'b00, c} << shift) | ({2'b00, c} >> (6 - shift));
  endfunction

endpackage

// File: rtl/vga_io_if.sv
// CPU I/O bus between the host and the VGA register front end.
interface vga_io_if;
  logic        io_req;
  logic        io_write;
  logic [15:0] io_port;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;

  modport master (output io_req, io_write, io_port, io_wdata, input io_rdata, io_ack);
  modport slave  (input io_req, io_write, io_port, io_wdata, output io_rdata, io_ack);
endinterface

// File: rtl/vga_dac_port.sv
// DAC palette write/read phase machines with auto-incrementing indices.
// Readback of the palette is built only when VGA_DAC_READ_EN is defined.
module vga_dac_port
  import vga_io_pkg::*;
#(
  parameter int unsigned DAC_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        widx_wr,
  input  logic        wdata_wr,
  input  logic        ridx_wr,
  input  logic        rdata_rd,
  input  logic [7:0]  wdata,
  output logic        dac_we,
  output logic [7:0]  dac_waddr,
  output logic [31:0] dac_wdata,
  output logic [7:0]  dac_raddr,
  input  logic [31:0] dac_rdata,
  output logic [7:0]  rd_byte,
  output logic        rd_late,
  output logic [7:0]  rd_late_byte
);

  dac_phase_t wphase;
  logic [7:0] widx;
  logic [5:0] r_lat, g_lat;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: the partial R/G latches are cleared along with the phase so a
      // reset mid-triplet leaves no stale colour behind.
      wphase    <= PH_R;
      widx      <= 8'h00;
      r_lat     <= 6'h00;
      g_lat     <= 6'h00;
      dac_we    <= 1'b0;
      dac_waddr <= 8'h00;
      dac_wdata <= 32'h0;
    end else begin
      dac_we <= 1'b0;
      if (widx_wr) begin
        widx   <= wdata;
        wphase <= PH_R;
      end else if (wdata_wr) begin
        case (wphase)
          PH_R: begin
            r_lat  <= wdata[5:0];
            wphase <= PH_G;
          end
          PH_G: begin
            g_lat  <= wdata[5:0];
            wphase <= PH_B;
          end
          default: begin
            dac_we    <= 1'b1;
            dac_waddr <= widx;
            dac_wdata <= {8'h00, dac_expand(r_lat, DAC_SHIFT), dac_expand(g_lat, DAC_SHIFT),
                          dac_expand(wdata[5:0], DAC_SHIFT)};
            widx      <= widx + 8'd1;
            wphase    <= PH_R;
          end
        endcase
      end
    end
  end

`ifdef VGA_DAC_READ_EN
  dac_phase_t  rphase;
  logic [7:0]  ridx;
  logic        fetch;   // RAM is sampling dac_raddr this cycle
  logic        live;    // dac_rdata holds the freshly fetched word this cycle
  logic [17:0] word;    // top six bits of R, G, B
  logic [17:0] cur;
  logic        unused_rdata;

  assign dac_raddr    = ridx;
  assign rd_late_byte = {2'b00, dac_rdata[23:18]};
  assign cur          = live ? {dac_rdata[23:18], dac_rdata[15:10], dac_rdata[7:2]} : word;
  assign unused_rdata = ^{dac_rdata[31:24], dac_rdata[17:16], dac_rdata[9:8], dac_rdata[1:0]};

  always_comb begin
    case (rphase)
      PH_R:    rd_byte = {2'b00, cur[17:12]};
      PH_G:    rd_byte = {2'b00, cur[11:6]};
      default: rd_byte = {2'b00, cur[5:0]};
    endcase
  end

  // A read landing while the word is still in flight is served straight from
  // dac_rdata in its ack cycle; such a read is always the R component.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rphase  <= PH_R;
      ridx    <= 8'h00;
      fetch   <= 1'b0;
      live    <= 1'b0;
      word    <= 18'h0;
      rd_late <= 1'b0;
    end else begin
      live    <= fetch;
      fetch   <= 1'b0;
      rd_late <= 1'b0;
      if (live) word <= cur;
      if (ridx_wr) begin
        ridx   <= wdata;
        rphase <= PH_R;
        fetch  <= 1'b1;
      end else if (rdata_rd) begin
        rd_late <= fetch;
        case (rphase)
          PH_R:    rphase <= PH_G;
          PH_G:    rphase <= PH_B;
          default: begin
            rphase <= PH_R;
            ridx   <= ridx + 8'd1;
            fetch  <= 1'b1;
          end
        endcase
      end
    end
  end
`else
  logic unused_rd;

  assign unused_rd    = ^{ridx_wr, rdata_rd, dac_rdata};
  assign dac_raddr    = 8'h00;
  assign rd_byte      = 8'h00;
  assign rd_late      = 1'b0;
  assign rd_late_byte = 8'h00;
`endif

endmodule

// File: rtl/vga_io.sv
// VGA CPU-side register front end: port decode, CRTC cursor registers, mode
// register, status read and DAC palette access. Optional macro: VGA_DAC_READ_EN.
module vga_io
  import vga_io_pkg::*;
#(
  parameter int unsigned DAC_SHIFT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  vga_io_if.slave     bus,
  input  logic        vretrace,
  input  logic        hblank,
  output logic        dac_we,
  output logic [7:0]  dac_waddr,
  output logic [31:0] dac_wdata,
  output logic [7:0]  dac_raddr,
  input  logic [31:0] dac_rdata,
  output logic [10:0] cursor,
  output logic [3:0]  cursor_sl,
  output logic [3:0]  cursor_sh,
  output logic [1:0]  videomode
);

  logic       wr_acc, rd_acc;
  logic [7:0] crtc_idx, crtc_val, rd_val, rdata_q;
  logic       ack_q;
  logic [7:0] dac_rd_byte, dac_rd_late_byte;
  logic       dac_rd_late;

  assign wr_acc = bus.io_req & bus.io_write;
  assign rd_acc = bus.io_req & ~bus.io_write;

  vga_dac_port #(.DAC_SHIFT(DAC_SHIFT)) u_dac (
    .clock        (clock),
    .reset_n      (reset_n),
    .widx_wr      (wr_acc && bus.io_port == PORT_DAC_WIDX),
    .wdata_wr     (wr_acc && bus.io_port == PORT_DAC_DATA),
    .ridx_wr      (wr_acc && bus.io_port == PORT_DAC_RIDX),
    .rdata_rd     (rd_acc && bus.io_port == PORT_DAC_DATA),
    .wdata        (bus.io_wdata),
    .dac_we       (dac_we),
    .dac_waddr    (dac_waddr),
    .dac_wdata    (dac_wdata),
    .dac_raddr    (dac_raddr),
    .dac_rdata    (dac_rdata),
    .rd_byte      (dac_rd_byte),
    .rd_late      (dac_rd_late),
    .rd_late_byte (dac_rd_late_byte)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    crtc_val = 8'h00;
    rd_val   = 8'hFF;
    case (crtc_idx)
      CRTC_CUR_START: crtc_val = {4'h0, cursor_sl};
      CRTC_CUR_END:   crtc_val = {4'h0, cursor_sh};
      CRTC_CUR_HI:    crtc_val = {5'h00, cursor[10:8]};
      CRTC_CUR_LO:    crtc_val = cursor[7:0];
      default:        crtc_val = 8'h00;
    endcase
    case (bus.io_port)
      PORT_CRTC_IDX:  rd_val = crtc_idx;
      PORT_CRTC_DATA: rd_val = crtc_val;
      PORT_DAC_WIDX,
      PORT_DAC_RIDX:  rd_val = 8'h00;
      PORT_DAC_DATA:  rd_val = dac_rd_byte;
      PORT_STATUS:    rd_val = {4'h0, vretrace, 2'b00, hblank | vretrace};
      PORT_MODE:      rd_val = {6'h00, videomode};
      default:        rd_val = 8'hFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      crtc_idx  <= 8'h00;
      cursor    <= 11'h000;
      cursor_sl <= CUR_SL_RESET;
      cursor_sh <= CUR_SH_RESET;
      videomode <= MODE_TEXT;
    end else begin
      ack_q <= bus.io_req;
      if (rd_acc) rdata_q <= rd_val;
      if (wr_acc) begin
        case (bus.io_port)
          PORT_CRTC_IDX: crtc_idx <= bus.io_wdata;
          PORT_MODE:     videomode <= bus.io_wdata[1:0];
          PORT_CRTC_DATA: begin
            case (crtc_idx)
              CRTC_CUR_START: cursor_sl    <= bus.io_wdata[3:0];
              CRTC_CUR_END:   cursor_sh    <= bus.io_wdata[3:0];
              CRTC_CUR_HI:    cursor[10:8] <= bus.io_wdata[2:0];
              CRTC_CUR_LO:    cursor[7:0]  <= bus.io_wdata;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.io_ack   = ack_q;
  assign bus.io_rdata = dac_rd_late ? dac_rd_late_byte : rdata_q;

endmodule

// File: tb/tb_vga_io.sv
// Directed bench for vga_io: table-driven register accesses plus hand-written
// DAC write, restart, reset-abort and palette readback sequences.
module tb_vga_io;
  import vga_io_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vretrace, hblank;
  logic        dac_we;
  logic [7:0]  dac_waddr, dac_raddr;
  logic [31:0] dac_wdata, dac_rdata;
  logic [10:0] cursor;
  logic [3:0]  cursor_sl, cursor_sh;
  logic [1:0]  videomode;

  vga_io_if bus ();

  vga_io #(.DAC_SHIFT(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .vretrace  (vretrace),
    .hblank    (hblank),
    .dac_we    (dac_we),
    .dac_waddr (dac_waddr),
    .dac_wdata (dac_wdata),
    .dac_raddr (dac_raddr),
    .dac_rdata (dac_rdata),
    .cursor    (cursor),
    .cursor_sl (cursor_sl),
    .cursor_sh (cursor_sh),
    .videomode (videomode)
  );

  always #5 clock = ~clock;

  // Palette RAM model with one cycle of read latency.
  logic [31:0] ram [256];
  always @(posedge clock) dac_rdata <= ram[dac_raddr];

  // DAC write scoreboard: log every strobe and flag back-to-back strobes.
  logic [39:0] we_log [$];
  logic        prev_we = 1'b0;
  int          we_consec = 0;
  always @(negedge clock) begin
    if (reset_n === 1'b1 && dac_we === 1'b1) we_log.push_back({dac_waddr, dac_wdata});
    if (prev_we && dac_we === 1'b1) we_consec++;
    prev_we = (dac_we === 1'b1);
  end

  int n_checks = 0;
  int n_errors = 0;
  logic       snap_ack;
  logic [7:0] snap_rdata;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Samples the bus outputs produced by the previous cycle, then drives the next one.
  task automatic step(input logic req, input logic wr, input logic [15:0] port, input logic [7:0] data);
    @(negedge clock);
    snap_ack   = bus.io_ack;
    snap_rdata = bus.io_rdata;
    bus.io_req   = req;
    bus.io_write = wr;
    bus.io_port  = port;
    bus.io_wdata = data;
  endtask

  task automatic access(input logic wr, input logic [15:0] port, input logic [7:0] data);
    step(1'b1, wr, port, data);
    step(1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] port;
    logic [7:0]  data;
    logic        vr;
    logic        hb;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t v(input logic wr, input logic [15:0] port, input logic [7:0] data,
                             input logic vr, input logic hb, input logic chk, input logic [7:0] exp);
    vec_t r;
    r.wr = wr; r.port = port; r.data = data; r.vr = vr; r.hb = hb; r.chk = chk; r.exp = exp;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[7] = 32'h00FC8040;
    bus.io_req = 1'b0; bus.io_write = 1'b0; bus.io_port = 16'h0; bus.io_wdata = 8'h0;
    vretrace = 1'b0; hblank = 1'b0;
    reset_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 16'h0, 8'h0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 16'h0, 8'h0);

    check("reset io_ack",    {39'h0, snap_ack}, 40'h0);
    check("reset io_rdata",  {32'h0, snap_rdata}, 40'h0);
    check("reset cursor",    {29'h0, cursor}, 40'h0);
    check("reset cursor_sl", {36'h0, cursor_sl}, 40'hE);
    check("reset cursor_sh", {36'h0, cursor_sh}, 40'hF);
    check("reset videomode", {38'h0, videomode}, 40'h0);
    check("reset dac_raddr", {32'h0, dac_raddr}, 40'h0);
    check("reset dac_we",    {39'h0, dac_we}, 40'h0);

    // wr, port, data, vretrace, hblank, check rdata, expected rdata
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h0A, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_DATA, 8'h00, 0, 0, 1, 8'h0E));
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h0B, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_DATA, 8'h00, 0, 0, 1, 8'h0F));
    vecs.push_back(v(0, PORT_CRTC_IDX,  8'h00, 0, 0, 1, 8'h0B));
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h0E, 0, 0, 0, 8'h00));
    vecs.push_back(v(1, PORT_CRTC_DATA, 8'h07, 0, 0, 0, 8'h00));
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h0F, 0, 0, 0, 8'h00));
    vecs.push_back(v(1, PORT_CRTC_DATA, 8'hCF, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_DATA, 8'h00, 0, 0, 1, 8'hCF));
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h0E, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_DATA, 8'h00, 0, 0, 1, 8'h07));
    vecs.push_back(v(1, PORT_CRTC_IDX,  8'h20, 0, 0, 0, 8'h00));
    vecs.push_back(v(1, PORT_CRTC_DATA, 8'h55, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_DATA, 8'h00, 0, 0, 1, 8'h00));
    vecs.push_back(v(0, PORT_CRTC_IDX,  8'h00, 0, 0, 1, 8'h20));
    vecs.push_back(v(1, PORT_MODE,      {6'h0, MODE_VGA256}, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, PORT_MODE,      8'h00, 0, 0, 1, 8'h02));
    vecs.push_back(v(0, PORT_STATUS,    8'h00, 1, 0, 1, 8'h09));
    vecs.push_back(v(0, PORT_STATUS,    8'h00, 0, 1, 1, 8'h01));
    vecs.push_back(v(0, PORT_STATUS,    8'h00, 1, 1, 1, 8'h09));
    vecs.push_back(v(0, PORT_STATUS,    8'h00, 0, 0, 1, 8'h00));
    vecs.push_back(v(1, 16'h1234,       8'hAB, 0, 0, 0, 8'h00));
    vecs.push_back(v(0, 16'h1234,       8'h00, 0, 0, 1, 8'hFF));

    foreach (vecs[i]) begin
      vretrace = vecs[i].vr;
      hblank   = vecs[i].hb;
      access(vecs[i].wr, vecs[i].port, vecs[i].data);
      check($sformatf("vec%0d port %h ack", i, vecs[i].port), {39'h0, snap_ack}, 40'h1);
      if (vecs[i].chk)
        check($sformatf("vec%0d port %h rdata", i, vecs[i].port), {32'h0, snap_rdata}, {32'h0, vecs[i].exp});
    end
    vretrace = 1'b0; hblank = 1'b0;

    check("cursor after writes", {29'h0, cursor}, {29'h0, 11'h7CF});
    check("videomode 320x200",   {38'h0, videomode}, {38'h0, MODE_VGA256});
    check("cursor_sl untouched", {36'h0, cursor_sl}, 40'hE);
    check("no dac_we yet",       40'(we_log.size()), 40'd0);

    // Back-to-back accesses: one ack per cycle, then the pulse drops.
    step(1'b1, 1'b1, PORT_CRTC_IDX, 8'h0A);
    step(1'b1, 1'b0, PORT_CRTC_DATA, 8'h00);
    check("b2b ack write", {39'h0, snap_ack}, 40'h1);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("b2b ack read",   {39'h0, snap_ack}, 40'h1);
    check("b2b rdata",      {32'h0, snap_rdata}, 40'h0E);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("ack single cycle", {39'h0, snap_ack}, 40'h0);

    // Six back-to-back DAC data writes from index FF: wraps to 00.
    access(1'b1, PORT_DAC_WIDX, 8'hFF);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h3F);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h00);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h20);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h01);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h02);
    step(1'b1, 1'b1, PORT_DAC_DATA, 8'h03);
    repeat (3) step(1'b0, 1'b0, 16'h0, 8'h0);
    check("dac write count",  40'(we_log.size()), 40'd2);
    check("dac write FF",     we_log[0], {8'hFF, 32'h00FF0082});
    check("dac write wrap 00", we_log[1], {8'h00, 32'h0004080C});

    // Index write mid-triplet restarts at R and discards the latched 3F.
    access(1'b1, PORT_DAC_WIDX, 8'h10);
    access(1'b1, PORT_DAC_DATA, 8'h3F);
    access(1'b1, PORT_DAC_WIDX, 8'h20);
    access(1'b1, PORT_DAC_DATA, 8'h01);
    access(1'b1, PORT_DAC_DATA, 8'h02);
    access(1'b1, PORT_DAC_DATA, 8'h03);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("restart count", 40'(we_log.size()), 40'd3);
    check("restart write", we_log[2], {8'h20, 32'h0004080C});

    // Reset in the middle of a triplet.
    access(1'b1, PORT_DAC_WIDX, 8'h05);
    access(1'b1, PORT_DAC_DATA, 8'h10);
    access(1'b1, PORT_DAC_DATA, 8'h11);
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    check("post-reset cursor",    {29'h0, cursor}, 40'h0);
    check("post-reset videomode", {38'h0, videomode}, 40'h0);
    check("no write on reset",    40'(we_log.size()), 40'd3);
    access(1'b1, PORT_DAC_DATA, 8'h01);
    access(1'b1, PORT_DAC_DATA, 8'h01);
    access(1'b1, PORT_DAC_DATA, 8'h01);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("reset-abort count", 40'(we_log.size()), 40'd4);
    check("reset-abort write", we_log[3], {8'h00, 32'h00040404});

`ifdef VGA_DAC_READ_EN
    // Read index 7 then three reads back-to-back; first read uses the bypass.
    step(1'b1, 1'b1, PORT_DAC_RIDX, 8'h07);
    step(1'b1, 1'b0, PORT_DAC_DATA, 8'h00);
    step(1'b1, 1'b0, PORT_DAC_DATA, 8'h00);
    check("dac read R", {32'h0, snap_rdata}, 40'h3F);
    step(1'b1, 1'b0, PORT_DAC_DATA, 8'h00);
    check("dac read G", {32'h0, snap_rdata}, 40'h20);
    step(1'b0, 1'b0, 16'h0, 8'h0);
    check("dac read B", {32'h0, snap_rdata}, 40'h10);
    check("dac read ack", {39'h0, snap_ack}, 40'h1);
    check("read index advanced", {32'h0, dac_raddr}, 40'h08);
`else
    access(1'b1, PORT_DAC_RIDX, 8'h07);
    access(1'b0, PORT_DAC_DATA, 8'h00);
    check("dac read disabled",  {32'h0, snap_rdata}, 40'h00);
    check("dac read ack",       {39'h0, snap_ack}, 40'h1);
    check("dac_raddr held",     {32'h0, dac_raddr}, 40'h00);
`endif

    check("dac_we never consecutive", 40'(we_consec), 40'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
